updi_start_ctrl: RTL and testbench
==================================

UPDI_START_CTRL -- requirements
Module: updi_start_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CLKS, default 1000000: consecutive stable samples needed to accept a button level (10 ms at 100 MHz).
REQ-002 Parameter ACK_TIMEOUT_CLKS, default 16: maximum cycles from the start pulse to busy rising before the attempt counts as failed.
REQ-003 Parameter RETRY_DELAY_CLKS, default 10000000: minimum idle cycles between a failed attempt and the next relaunch.
REQ-004 Parameter MAX_RETRIES, default 3: relaunches allowed after the first failed attempt; range 0..15.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start_btn  input  1  raw, asynchronous, bouncing start button; active-high.
REQ-008 busy  input  1  programmer busy, synchronous to clk.
REQ-009 error  input  1  programmer error, synchronous to clk; may be held for many cycles.
REQ-010 start  output  1  one-cycle launch pulse to the programmer start input.
REQ-011 retry_count  output  4  number of relaunches performed in the current session.
REQ-012 done  output  1  sticky flag: the session completed without error.
REQ-013 failed  output  1  sticky flag: the retry budget is exhausted.

Function
REQ-014 start_btn SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CLKS consecutive synchronized samples that differ from the current debounced level.
REQ-015 A press event SHALL be a one-cycle 0->1 edge of the debounced level; releases generate no event.
REQ-016 The FSM SHALL have the states IDLE, LAUNCH, WAIT_ACK, RUN, BACKOFF, DONE and FAIL.
REQ-017 IDLE/DONE/FAIL + press event -> LAUNCH; on that transition retry_count, done and failed are cleared.
REQ-018 LAUNCH SHALL assert start for exactly one cycle and then move to WAIT_ACK, clearing the timeout counter.
REQ-019 WAIT_ACK: busy=1 -> RUN; error=1, or ACK_TIMEOUT_CLKS cycles without busy -> failed-attempt handling (REQ-021).
REQ-020 RUN: error=1 -> failed-attempt handling; busy=0 with error=0 -> DONE and done=1 in the same cycle; error takes priority when busy falls in the same cycle that error asserts.
REQ-021 Failed-attempt handling:
  - if retry_count == MAX_RETRIES -> FAIL and set failed=1;
  - otherwise increment retry_count and move to BACKOFF.
REQ-022 BACKOFF SHALL count RETRY_DELAY_CLKS cycles; it moves to LAUNCH only when the count has expired and error=0, and it stays in BACKOFF while error remains held.
REQ-023 Press events in LAUNCH, WAIT_ACK, RUN and BACKOFF SHALL be ignored (no queuing).
REQ-024 retry_count SHALL saturate at MAX_RETRIES and never wrap.
REQ-025 With MAX_RETRIES=0, the first failed attempt SHALL go directly to FAIL with retry_count=0.
REQ-026 start SHALL be high only in LAUNCH; the latency from the press event to start is 1 cycle.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, regardless of state (including mid-RUN or mid-BACKOFF):
  - state=IDLE and start=0;
  - retry_count=0, done=0, failed=0;
  - synchronizer flops, debounced level, debounce counter and delay counters all 0.
REQ-028 After reset deassertion, a button already held SHALL produce a press event after DEBOUNCE_CLKS+2 cycles.

Structure
REQ-029 A shared package updi_pkg SHALL hold the FSM state enum typedef and the retry_count width constant (4).
REQ-030 The synchronizer plus debouncer SHALL be one sub-module, updi_debounce, parameterized by DEBOUNCE_CLKS and outputting the debounced level and the rise pulse.
REQ-031 The ACK timeout and BACKOFF delay SHALL share one down-counter sized by $clog2 of the larger parameter.

Verification (DEBOUNCE_CLKS=4, ACK_TIMEOUT_CLKS=4, RETRY_DELAY_CLKS=8, MAX_RETRIES=2)
REQ-032 Bounce filter: start_btn toggling every 2 cycles for 20 cycles, then held high -> exactly one start pulse, 7 cycles after the hold begins (2 sync + 4 debounce + 1 LAUNCH).
REQ-033 Clean pass: press; busy=1 two cycles after start, held 50 cycles, then 0 -> done=1 on the busy-fall cycle, retry_count=0, single start pulse.
REQ-034 Retry path: error pulses 10 cycles into each RUN, three attempts -> starts at least 8 cycles after each error clears, retry_count 0->1->2, then FAIL with failed=1 and no fourth start.
REQ-035 Ack timeout: busy never rises -> failed attempt 4 cycles after start, BACKOFF, relaunch; error held 20 cycles in BACKOFF delays relaunch until error=0.
REQ-036 Priority and ignore: error=1 and busy 1->0 in the same RUN cycle -> BACKOFF, not DONE; a second press during RUN -> no extra start pulse.
REQ-037 Reset mid-RUN: rst_n low for 1 cycle -> start, done, failed and retry_count are 0 in the same cycle; the next press relaunches normally.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared types and constants for the UPDI start controller.
// State encoding, retry counter width and counter sizing helper.
package updi_pkg;

    localparam int RC_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_RUN,
        S_BACKOFF,
        S_DONE,
        S_FAIL
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/updi_debounce.sv
// Start button synchronizer and debouncer.
// Emits the debounced level and a one-cycle rise pulse.
module updi_debounce
    import updi_pkg::*;
#(
    parameter int DEBOUNCE_CLKS = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int DW = cnt_w(DEBOUNCE_CLKS);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          rise_q;
    logic          rise_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DW'(DEBOUNCE_CLKS - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/updi_start_ctrl.sv
// Launches the UPDI programmer from a button press and
// retries failed attempts with a back-off delay.
module updi_start_ctrl
    import updi_pkg::*;
#(
    parameter int DEBOUNCE_CLKS    = 1000000,
    parameter int ACK_TIMEOUT_CLKS = 16,
    parameter int RETRY_DELAY_CLKS = 10000000,
    parameter int MAX_RETRIES      = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_btn,
    input  logic            busy,
    input  logic            error,
    output logic            start,
    output logic [RC_W-1:0] retry_count,
    output logic            done,
    output logic            failed
);

    localparam int CMAX = (ACK_TIMEOUT_CLKS > RETRY_DELAY_CLKS)
                        ? ACK_TIMEOUT_CLKS : RETRY_DELAY_CLKS;
    localparam int CW   = cnt_w(CMAX);

    state_e          state_q;
    state_e          state_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_d;
    logic            done_q;
    logic            done_d;
    logic            failed_q;
    logic            failed_d;
    logic            btn_level;
    logic            btn_rise;
    logic            press;
    logic            fail_att;

    updi_debounce #(
        .DEBOUNCE_CLKS(DEBOUNCE_CLKS)
    ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (start_btn),
        .level(btn_level),
        .rise (btn_rise)
    );

    assign press = btn_rise & btn_level;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rc_d     = rc_q;
        done_d   = done_q;
        failed_d = failed_q;
        fail_att = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (press) begin
                    state_d  = S_LAUNCH;
                    rc_d     = '0;
                    done_d   = 1'b0;
                    failed_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_ACK;
                cnt_d   = CW'(ACK_TIMEOUT_CLKS - 1);
            end
            S_WAIT_ACK: begin
                if (error || (!busy && cnt_q == '0)) begin
                    fail_att = 1'b1;
                end else if (busy) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RUN: begin
                if (error) begin
                    fail_att = 1'b1;
                end else if (!busy) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_BACKOFF: begin
                // delay keeps running under error; only the exit waits
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!error) begin
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (fail_att) begin
            if (rc_q == RC_W'(MAX_RETRIES)) begin
                state_d  = S_FAIL;
                failed_d = 1'b1;
            end else begin
                state_d = S_BACKOFF;
                rc_d    = rc_q + RC_W'(1);
                cnt_d   = CW'(RETRY_DELAY_CLKS - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rc_q     <= '0;
            done_q   <= 1'b0;
            failed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rc_q     <= rc_d;
            done_q   <= done_d;
            failed_q <= failed_d;
        end
    end

    assign start       = (state_q == S_LAUNCH);
    assign retry_count = rc_q;
    assign done        = done_q;
    assign failed      = failed_q;

endmodule

// File: tb/tb_updi_start_ctrl.sv
// Bench for updi_start_ctrl: scripted sessions with a
// scoreboard of expected start pulses (cycle, retry_count).
module tb_updi_start_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       busy = 1'b0;
    logic       error = 1'b0;
    logic       start;
    logic       done;
    logic       failed;
    logic [3:0] retry_count;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        int cyc;
        int rc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    updi_start_ctrl #(
        .DEBOUNCE_CLKS   (4),
        .ACK_TIMEOUT_CLKS(4),
        .RETRY_DELAY_CLKS(8),
        .MAX_RETRIES     (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_btn  (start_btn),
        .busy       (busy),
        .error      (error),
        .start      (start),
        .retry_count(retry_count),
        .done       (done),
        .failed     (failed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start) begin
            if (sb.size() == 0) begin
                chk("start_extra", cyc, -1);
            end else begin
                mon_e = sb.pop_front();
                chk("start_cyc", cyc, mon_e.cyc);
                chk("start_rc", int'(retry_count), mon_e.rc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cyc(int c);
        while (cyc < c) tick();
    endtask

    task automatic exp_start(int c, int rc);
        exp_t e;
        e.cyc = c;
        e.rc  = rc;
        sb.push_back(e);
    endtask

    int h;
    int s;

    initial begin
        // reset state
        repeat (3) tick();
        chk("rst_start", int'(start), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_failed", int'(failed), 0);
        chk("rst_rc", int'(retry_count), 0);
        rst_n = 1'b1;

        // bounce filter, clean pass, press ignored in RUN
        at_cyc(cyc + 3);
        for (int k = 0; k < 20; k++) begin
            start_btn = ((k / 2) % 2 == 0);
            tick();
        end
        h = cyc;
        start_btn = 1'b1;
        s = h + 7;
        exp_start(s, 0);
        at_cyc(s + 2);
        busy = 1'b1;
        at_cyc(s + 10);
        start_btn = 1'b0;
        at_cyc(s + 20);
        start_btn = 1'b1;
        at_cyc(s + 30);
        start_btn = 1'b0;
        at_cyc(s + 52);
        busy = 1'b0;
        chk("done_early", int'(done), 0);
        tick();
        chk("done_set", int'(done), 1);
        chk("done_rc", int'(retry_count), 0);
        chk("done_failed", int'(failed), 0);

        // retry path to FAIL
        at_cyc(s + 70);
        h = cyc;
        start_btn = 1'b1;
        s = h + 7;
        exp_start(s, 0);
        at_cyc(s + 1);
        chk("done_clr", int'(done), 0);
        for (int a = 0; a < 3; a++) begin
            at_cyc(s + 2);
            busy = 1'b1;
            if (a == 0) begin
                at_cyc(s + 4);
                start_btn = 1'b0;
            end
            at_cyc(s + 13);
            error = 1'b1;
            at_cyc(s + 14);
            error = 1'b0;
            busy = 1'b0;
            if (a < 2) begin
                chk("rc_inc", int'(retry_count), a + 1);
                chk("rc_nofail", int'(failed), 0);
                s = s + 22;
                exp_start(s, a + 1);
            end else begin
                chk("fail_set", int'(failed), 1);
                chk("fail_rc", int'(retry_count), 2);
            end
        end
        at_cyc(s + 50);
        chk("fail_hold", int'(failed), 1);
        chk("fail_rc_sat", int'(retry_count), 2);

        // ack timeout, error held in BACKOFF
        h = cyc;
        start_btn = 1'b1;
        s = h + 7;
        exp_start(s, 0);
        at_cyc(s + 1);
        chk("failed_clr", int'(failed), 0);
        at_cyc(s + 3);
        start_btn = 1'b0;
        at_cyc(s + 4);
        chk("to_rc_pre", int'(retry_count), 0);
        at_cyc(s + 5);
        chk("to_rc_post", int'(retry_count), 1);
        at_cyc(s + 6);
        error = 1'b1;
        at_cyc(s + 26);
        error = 1'b0;
        s = s + 27;
        exp_start(s, 1);

        // error wins over busy fall
        at_cyc(s + 2);
        busy = 1'b1;
        at_cyc(s + 10);
        busy = 1'b0;
        error = 1'b1;
        at_cyc(s + 11);
        error = 1'b0;
        chk("prio_done", int'(done), 0);
        chk("prio_rc", int'(retry_count), 2);
        s = s + 19;
        exp_start(s, 2);

        // reset mid-RUN with button held through it
        at_cyc(s + 2);
        busy = 1'b1;
        at_cyc(s + 5);
        start_btn = 1'b1;
        at_cyc(s + 6);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", int'(start), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_failed", int'(failed), 0);
        chk("mid_rst_rc", int'(retry_count), 0);
        tick();
        rst_n = 1'b1;
        busy = 1'b0;
        s = cyc + 7;
        exp_start(s, 0);
        at_cyc(s + 2);
        busy = 1'b1;
        at_cyc(s + 10);
        busy = 1'b0;
        chk("post_rst_busy", int'(done), 0);
        at_cyc(s + 11);
        chk("post_rst_done", int'(done), 1);
        chk("post_rst_rc", int'(retry_count), 0);
        start_btn = 1'b0;

        at_cyc(s + 20);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
